// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: PC-source codes issued by
// the ID-stage controller, the NOP encoding and the default vector addresses.
package cpu_pkg;

  // PC source selected by the controller for the instruction currently in ID.
  // Codes 6 and 7 are unused by the controller and are treated as exceptions.
  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_JR     = 3'd3,
    PCSRC_IRQ    = 3'd4,
    PCSRC_EXPT   = 3'd5
  } pc_src_e;

  // All-zero word is sll r0,r0,0: the pipeline bubble instruction.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Default vectors; bit 31 set means supervisor space.
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_PC  = 32'h8000_0008;

endpackage : cpu_pkg

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: controller and
// EX-stage redirect inputs, instruction-memory port and the IF/ID register.
interface if_stage_if;

  logic        stall;
  logic [2:0]  id_pc_src;
  logic [25:0] id_jump_index;
  logic [31:0] id_jr_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        if_id_irq;
  logic        pc_super;

  // Surrounding pipeline / memory side.
  modport master (
    output stall, id_pc_src, id_jump_index, id_jr_target,
           ex_branch_taken, ex_branch_target, irq, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
           if_id_irq, pc_super
  );

  // Fetch stage side.
  modport slave (
    input  stall, id_pc_src, id_jump_index, id_jr_target,
           ex_branch_taken, ex_branch_target, irq, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
           if_id_irq, pc_super
  );

endinterface : if_stage_if

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage. Purely combinational: computes the
// sequential PC and resolves EX-branch and ID-redirect requests into one
// next PC plus a flag saying the IF/ID register must take a bubble.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
  input  logic [31:0] pc_i,
  input  logic [3:0]  id_region_i,       // if_id_pc_plus4[31:28]
  input  logic        id_valid_i,
  input  logic [2:0]  id_pc_src_i,
  input  logic [25:0] id_jump_index_i,
  input  logic [31:0] id_jr_target_i,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_branch_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        flush_o
);

  logic        id_redirect;
  logic [31:0] id_target;

  // Sequential PC keeps the mode bit; only the low 31 bits wrap.
  assign pc_plus4_o = {pc_i[31], pc_i[30:0] + 31'd4};

  // Decode the ID-stage redirect target from the controller's PC source.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    id_redirect = 1'b0;
    id_target   = pc_plus4_o;
    case (id_pc_src_i)
      PCSRC_JUMP: begin
        id_redirect = 1'b1;
        id_target   = {id_region_i, id_jump_index_i, 2'b00};
      end
      PCSRC_JR: begin
        id_redirect = 1'b1;
        id_target   = id_jr_target_i;
      end
      PCSRC_IRQ: begin
        id_redirect = 1'b1;
        id_target   = ILLOP_PC;
      end
      PCSRC_EXPT, 3'd6, 3'd7: begin
        id_redirect = 1'b1;
        id_target   = XADR_PC;
      end
      default: ;  // sequential and branch: branches resolve in EX
    endcase
  end

  // EX branch outranks an ID redirect; a bubble ID slot cannot redirect.
  always_comb begin
    next_pc_o = pc_plus4_o;
    flush_o   = 1'b0;
    if (ex_branch_taken_i) begin
      next_pc_o = ex_branch_target_i;
      flush_o   = 1'b1;
    end else if (id_valid_i && id_redirect) begin
      next_pc_o = id_target;
      flush_o   = 1'b1;
    end
  end

endmodule : pc_next_sel

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register,
// drives the instruction-memory address and tags fetches with pending IRQs.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] ILLOP_PC = DEF_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = DEF_XADR_PC
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.slave  bus
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q,    valid_d;
  logic        irq_q,      irq_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        flush;
  logic        advance;

  pc_next_sel #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_pc_next_sel (
    .pc_i               (pc_q),
    .id_region_i        (pc_plus4_q[31:28]),
    .id_valid_i         (valid_q),
    .id_pc_src_i        (bus.id_pc_src),
    .id_jump_index_i    (bus.id_jump_index),
    .id_jr_target_i     (bus.id_jr_target),
    .ex_branch_taken_i  (bus.ex_branch_taken),
    .ex_branch_target_i (bus.ex_branch_target),
    .pc_plus4_o         (pc_plus4),
    .next_pc_o          (next_pc),
    .flush_o            (flush)
  );

  // A taken EX branch must squash the stalled slot, so it breaks the stall.
  assign advance = bus.ex_branch_taken | ~bus.stall;

  // Next-state for PC and IF/ID: hold, bubble, or load the fetched word.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    irq_d      = irq_q;
    if (advance) begin
      pc_d = next_pc;
      if (flush) begin
        // Bubble carries the new PC so pc_super follows the new mode.
        instr_d    = NOP_WORD;
        pc_plus4_d = next_pc;
        valid_d    = 1'b0;
        irq_d      = 1'b0;
      end else begin
        instr_d    = bus.imem_rdata;
        pc_plus4_d = pc_plus4;
        valid_d    = 1'b1;
        irq_d      = bus.irq & ~pc_q[31];
      end
    end
  end

  // PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= RESET_PC;
      valid_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc_plus4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.if_id_irq      = irq_q;
  assign bus.pc_super       = pc_plus4_q[31];

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage: reset, jumps, jr mode change, branch
// versus stall priority, stall hold, IRQ tagging and PC wrap.
module tb_if_stage;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the whole IF/ID state plus PC in one call.
  task automatic check_all(input string tag, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] pc4,
                           input logic valid, input logic irqt);
    check({tag, ".addr"},  bus.imem_addr,             addr);
    check({tag, ".instr"}, bus.if_id_instr,           instr);
    check({tag, ".pc4"},   bus.if_id_pc_plus4,        pc4);
    check({tag, ".valid"}, {31'd0, bus.if_id_valid},  {31'd0, valid});
    check({tag, ".irq"},   {31'd0, bus.if_id_irq},    {31'd0, irqt});
    check({tag, ".super"}, {31'd0, bus.pc_super},     {31'd0, pc4[31]});
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    bus.ex_branch_taken  = 1'b1;
    bus.ex_branch_target = tgt;
    step();
    bus.ex_branch_taken  = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset                = 1'b1;
    bus.stall            = 1'b0;
    bus.id_pc_src        = 3'd0;
    bus.id_jump_index    = 26'd0;
    bus.id_jr_target     = 32'd0;
    bus.ex_branch_taken  = 1'b0;
    bus.ex_branch_target = 32'd0;
    bus.irq              = 1'b0;
    bus.imem_rdata       = 32'd0;
    step();
    step();
    check_all("reset", 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0, 1'b0);

    // First fetches after reset.
    reset = 1'b0;
    bus.imem_rdata = 32'h11;
    step();
    check_all("fetch1", 32'h8000_0004, 32'h11, 32'h8000_0004, 1'b1, 1'b0);
    bus.imem_rdata = 32'h22;
    step();
    check_all("fetch2", 32'h8000_0008, 32'h22, 32'h8000_0008, 1'b1, 1'b0);

    // jr from supervisor to user space; bubble already shows user mode.
    bus.id_pc_src    = 3'd3;
    bus.id_jr_target = 32'h0040_0000;
    step();
    check_all("jr", 32'h0040_0000, 32'h0, 32'h0040_0000, 1'b0, 1'b0);
    bus.id_pc_src  = 3'd0;
    bus.imem_rdata = 32'h33;
    step();
    check_all("jr_load", 32'h0040_0004, 32'h33, 32'h0040_0004, 1'b1, 1'b0);
    bus.imem_rdata = 32'h44;
    step();
    check_all("seq", 32'h0040_0008, 32'h44, 32'h0040_0008, 1'b1, 1'b0);

    // j with index 0x10 in region 0 -> 0x40.
    bus.id_pc_src     = 3'd2;
    bus.id_jump_index = 26'h10;
    step();
    check_all("jump", 32'h0000_0040, 32'h0, 32'h0000_0040, 1'b0, 1'b0);
    // Redirect code against a bubble in ID must be ignored.
    bus.id_jump_index = 26'h20;
    bus.imem_rdata    = 32'h55;
    step();
    check_all("bubble_nojump", 32'h0000_0044, 32'h55, 32'h0000_0044, 1'b1, 1'b0);

    // EX branch beats stall and jr in the same cycle.
    bus.id_pc_src    = 3'd3;
    bus.id_jr_target = 32'h1234_5678;
    bus.stall        = 1'b1;
    branch_to(32'h0040_0100);
    check_all("br_vs_stall", 32'h0040_0100, 32'h0, 32'h0040_0100, 1'b0, 1'b0);
    bus.stall     = 1'b0;
    bus.id_pc_src = 3'd0;

    // Stall for two edges at 0x00400020.
    branch_to(32'h0040_0020);
    bus.stall      = 1'b1;
    bus.imem_rdata = 32'h77;
    step();
    check_all("stall1", 32'h0040_0020, 32'h0, 32'h0040_0020, 1'b0, 1'b0);
    step();
    check_all("stall2", 32'h0040_0020, 32'h0, 32'h0040_0020, 1'b0, 1'b0);
    bus.stall = 1'b0;
    step();
    check_all("resume", 32'h0040_0024, 32'h77, 32'h0040_0024, 1'b1, 1'b0);

    // Stall outranks an ID exception redirect; it is taken once released.
    bus.stall     = 1'b1;
    bus.id_pc_src = 3'd5;
    step();
    check_all("stall_vs_expt", 32'h0040_0024, 32'h77, 32'h0040_0024, 1'b1, 1'b0);
    bus.stall = 1'b0;
    step();
    check_all("expt", 32'h8000_0008, 32'h0, 32'h8000_0008, 1'b0, 1'b0);
    bus.id_pc_src = 3'd0;

    // IRQ tagged in user space, vectored, not tagged in supervisor space.
    branch_to(32'h0040_0010);
    bus.irq        = 1'b1;
    bus.imem_rdata = 32'h88;
    step();
    check_all("irq_tag", 32'h0040_0014, 32'h88, 32'h0040_0014, 1'b1, 1'b1);
    bus.id_pc_src = 3'd4;
    step();
    check_all("irq_vec", 32'h8000_0004, 32'h0, 32'h8000_0004, 1'b0, 1'b0);
    bus.id_pc_src  = 3'd0;
    bus.imem_rdata = 32'h99;
    step();
    check_all("irq_super", 32'h8000_0008, 32'h99, 32'h8000_0008, 1'b1, 1'b0);
    bus.irq = 1'b0;

    // Code 7 behaves as the exception vector.
    branch_to(32'h0040_0200);
    bus.imem_rdata = 32'hAA;
    step();
    bus.id_pc_src = 3'd7;
    step();
    check("code7.addr", bus.imem_addr, 32'h8000_0008);
    bus.id_pc_src = 3'd0;

    // Wrap keeps bit 31.
    branch_to(32'hFFFF_FFFC);
    check("wrap_s.pre", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_rdata = 32'hBB;
    step();
    check_all("wrap_s", 32'h8000_0000, 32'hBB, 32'h8000_0000, 1'b1, 1'b0);
    branch_to(32'h7FFF_FFFC);
    step();
    check_all("wrap_u", 32'h0000_0000, 32'hBB, 32'h0000_0000, 1'b1, 1'b0);

    // Reset wins over a simultaneous branch.
    reset = 1'b1;
    branch_to(32'h0040_0300);
    check_all("reset2", 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_stage

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS CPU, directly upstream of the ID-stage controller. It holds the PC and selects the next PC from the controller's 3-bit PC-source code and from the EX-stage branch resolution. It drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register. It also produces the supervisor flag and the IRQ tag that the controller consumes.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset (supervisor space)
ILLOP_PC, 32'h8000_0004, interrupt vector (PC-source code 4)
XADR_PC, 32'h8000_0008, exception vector (PC-source code 5)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  load-use hazard; hold PC and IF/ID
id_pc_src  in  3  controller PC source for the ID instruction: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 IRQ, 5 exception
id_jump_index  in  26  instr[25:0] of the ID instruction
id_jr_target  in  32  forwarded rs value for jr/jalr
ex_branch_taken  in  1  branch in EX resolved taken
ex_branch_target  in  32  branch target from EX
irq  in  1  external interrupt request, level
imem_addr  out  32  instruction-memory address (= PC)
imem_rdata  in  32  instruction word, combinational read
if_id_instr  out  32  instruction in ID
if_id_pc_plus4  out  32  PC+4 of the ID instruction
if_id_valid  out  1  0 = bubble
if_id_irq  out  1  IRQ tag for the ID instruction
pc_super  out  1  = if_id_pc_plus4[31]; supervisor flag to the controller

Behaviour:
- Reset is synchronous: PC <= RESET_PC; if_id_instr <= 0 (NOP); if_id_pc_plus4 <= RESET_PC; if_id_valid <= 0; if_id_irq <= 0.
- imem_addr = PC, combinationally. Fetch latency is 1 cycle: the word at PC appears on if_id_instr after the next edge.
- Sequential increment: pc_plus4 = {PC[31], PC[30:0] + 4}. Bit 31 is preserved; the low 31 bits wrap.
- ID redirect targets:
  - code 2: {if_id_pc_plus4[31:28], id_jump_index, 2'b00}
  - code 3: id_jr_target, all 32 bits; may leave supervisor mode
  - code 4: ILLOP_PC
  - code 5, 6, 7: XADR_PC
  - codes 0 and 1: no redirect; branches resolve in EX.
- The ID redirect is honoured only when if_id_valid = 1.
- Per-edge priority, highest first:
  1. reset.
  2. ex_branch_taken: PC <= ex_branch_target; IF/ID <= bubble. Overrides stall and any ID redirect in the same cycle.
  3. stall: PC and all IF/ID outputs hold.
  4. ID redirect: PC <= target; IF/ID <= bubble.
  5. Otherwise: PC <= pc_plus4; if_id_instr <= imem_rdata; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1; if_id_irq <= irq & ~PC[31].
- Bubble contents: instr 0, valid 0, irq 0, if_id_pc_plus4 <= new PC, so pc_super tracks the new mode.
- IRQ tagging:
  - Never tagged while PC[31] = 1.
  - A tag dropped by a flush is re-tagged on the next loaded fetch while irq is still high.
  - irq is not latched internally; the source holds it until serviced.

Decomposition:
- Shared package cpu_pkg:
  - PC-source code constants (PCSRC_SEQ, BRANCH, JUMP, JR, IRQ, EXPT).
  - NOP word.
  - Default vector values.
- One combinational sub-module, pc_next_sel: takes PC, if_id_pc_plus4, the codes and targets; returns next_pc and flush. The PC/IF-ID registers and stall handling stay in if_stage.

Test Plan:
- Reset: release reset, memory returns 0x11, 0x22 → imem_addr 0x80000000 then 0x80000004. The cycle after the first post-reset edge shows if_id_instr 0x11, valid 1, pc_plus4 0x80000004, pc_super 1.
- Jump: ID valid, if_id_pc_plus4 0x00400008, id_pc_src 2, index 26'h10 → PC 0x00000040; next cycle valid 0, instr 0.
- Branch vs stall: ex_branch_taken 1, target 0x00400100, stall 1, id_pc_src 3 → PC 0x00400100, bubble. Stall and jr are both ignored.
- Stall: stall high for 2 cycles at PC 0x00400020 → imem_addr and all if_id_* unchanged for 2 edges; resumes at 0x00400024.
- IRQ:
  - Fetching at PC 0x00400010 with irq 1 → if_id_irq 1.
  - Then id_pc_src 4 → PC 0x80000004, bubble.
  - Fetch at 0x80000004 with irq 1 → if_id_irq 0.
- Mode/wrap:
  - jr to 0x00400000 from supervisor → pc_super 0 after the next load.
  - PC 0xFFFFFFFC sequential → next PC 0x80000000.
  - PC 0x7FFFFFFC sequential → next PC 0x00000000.
